timer_core_param: RTL and testbench
===================================

Name: timer_core_param

Overview:
- Parametrised two-stage modulo timer core.
- Successor to the fixed 8-bit MSB/LSB timer core. Adds configurable digit width and per-stage modulus, up/down mode, a single-cycle tick enable instead of a gated clock, an end-match done flag, optional auto-reload, and an explicit run/pause state machine.
- Sits between the prescaler (which produces `tick`) and the binary-to-display conversion.

Parameters:
- DIGIT_W, 8: width of each stage counter and of its value ports.
- LSB_MOD, 60: LSB stage modulus. Legal range 2..2^DIGIT_W.
- MSB_MOD, 60: MSB stage modulus. Legal range 2..2^DIGIT_W.
- AUTO_RELOAD, 0: 1 = on end-match, reload the load values and keep running; 0 = freeze in DONE.

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous active-high reset.
- tick  in  1  count enable, one clk cycle wide, from the prescaler.
- run  in  1  level. 1 = start/continue, 0 = pause.
- mode  in  1  0 = count up, 1 = count down. Sampled on each tick.
- load  in  1  one-cycle strobe: load `msb_loadval` / `lsb_loadval`.
- clear  in  1  one-cycle strobe: load `msb_resetval` / `lsb_resetval` and go to IDLE.
- msb_loadval, lsb_loadval  in  DIGIT_W  preset values.
- msb_resetval, lsb_resetval  in  DIGIT_W  clear values.
- msb_end, lsb_end  in  DIGIT_W  end-match target.
- lsb_out, msb_out  out  DIGIT_W  current count, registered.
- running  out  1  1 while in RUN.
- done  out  1  sticky; set on end-match, cleared by load, clear or rst.
- done_pulse  out  1  one cycle high on each end-match.
- lsb_carry  out  1  one cycle high when the LSB stage wraps in either direction.

Behaviour:
- Reset (async, rst=1): lsb_out=0, msb_out=0, state=IDLE. running, done, done_pulse and lsb_carry are all 0.
- States:
  - IDLE: run=1 → RUN.
  - RUN: run=0 → PAUSE; end-match with AUTO_RELOAD=0 → DONE.
  - PAUSE: run=1 → RUN.
  - DONE: holds. run and tick are ignored. Exits only via load (→ IDLE, or → RUN if run=1 in the same cycle) or clear (→ IDLE).
- Per-cycle priority: rst > clear > load > tick step.
  - When load or clear is active, a tick in the same cycle is dropped.
- A tick steps the count only in RUN. Outputs update on the clk edge that samples the tick (latency 1).
- Up step:
  - lsb == LSB_MOD-1 → lsb = 0, lsb_carry = 1, msb steps up.
  - msb == MSB_MOD-1 while stepping → msb = 0 (full wrap).
  - Otherwise lsb + 1.
- Down step:
  - lsb == 0 → lsb = LSB_MOD-1, lsb_carry = 1, msb steps down.
  - msb == 0 while stepping → msb = MSB_MOD-1.
  - Otherwise lsb - 1.
- End-match: evaluated only on the post-step value of a tick step, never on a loaded or cleared value. A match is {msb,lsb}_next == {msb_end,lsb_end}.
  - The matching value is written to the outputs, done_pulse = 1, done = 1.
  - AUTO_RELOAD=0: state → DONE; the count holds the matched value.
  - AUTO_RELOAD=1: the next tick loads the load values instead of stepping (the matched value is visible for one tick period). State stays RUN. done_pulse fires on each match.
- Load/clear values ≥ modulus are clamped to modulus-1. End values ≥ modulus never match.
- A mode change mid-run takes effect on the next tick. There is no other side effect.
- run falling and tick arriving in the same cycle: the tick is still applied, because the state is RUN when sampled. PAUSE applies from the next cycle.
- done_pulse and lsb_carry are single-cycle registered outputs.

Decomposition:
- Shared package `timer_pkg`:
  - State encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE (2 bits).
  - Default modulus constants (60, 100, 24).
- One sub-module, `timer_mod_stage`:
  - Parameters: W, MOD.
  - Inputs: en, dir, load, ld_val.
  - Outputs: val, wrap.
  - Instantiated twice. The MSB stage en = tick-step & LSB wrap.
  - Clamping is done in the stage.

Test Plan:
- Default params, rst then run=1, mode=0, tick every cycle, end 2:00 → lsb counts 0..59; lsb_carry at 59→0; msb 0→1→2; done_pulse exactly once at 2:00; state DONE; further ticks hold 2:00.
- mode=1, load 1:00, end 0:00, run=1 → sequence 1:00, 0:59 … 0:00; done=1 after 60 ticks.
- Pause: run=0 after 10 ticks, 5 ticks while paused, then run=1 → count resumes at 0:10; running=0 during pause.
- Wrap up: MSB_MOD=3, load 2:59, end 1:00, run → next tick 0:00 with lsb_carry=1; match later at 1:00.
- Priority: load=1, clear=1 and tick in the same cycle → clear values win, IDLE, done=0. Separately, load 70 with LSB_MOD=60 → lsb_out=59.
- AUTO_RELOAD=1, load 0:05, end 0:08, up → 0:06, 0:07, 0:08 (done_pulse), then 0:05; running stays 1. Async rst mid-count → outputs 0 immediately, without a clk edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the modulo timer core: FSM state encoding and common moduli.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Common stage moduli: seconds/minutes, percent/centi, hours.
    localparam int MOD_SEC  = 60;
    localparam int MOD_PCT  = 100;
    localparam int MOD_HOUR = 24;

endpackage

// File: rtl/timer_mod_stage.sv
// One modulo-MOD up/down counter digit with clamped synchronous load.
// Latency: val updates on the clk edge after en/load; nxt and wrap are combinational.
// Backpressure: none; load overrides en.
//   clk, rst    : clock, async active-high reset (val -> 0)
//   en, dir     : step enable, direction (0 = up, 1 = down)
//   load, ld_val: load strobe and value (values >= MOD clamp to MOD-1)
//   val         : registered count
//   nxt         : value val takes on the next edge (used for end-match)
//   wrap        : en is stepping across the modulus boundary this cycle
module timer_mod_stage
    import timer_pkg::*;
#(
    parameter int W   = 8,
    parameter int MOD = MOD_SEC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] val,
    output logic [W-1:0] nxt,
    output logic         wrap
);

    // One extra bit so MOD = 2^W is representable in the clamp compare.
    localparam logic [W:0]   MOD_V = (W+1)'(MOD);
    localparam logic [W-1:0] TOP   = W'(MOD - 1);

    logic [W-1:0] ld_clamped;

    always_comb begin
        ld_clamped = ({1'b0, ld_val} >= MOD_V) ? TOP : ld_val;
    end

    always_comb begin
        wrap = en & (dir ? (val == '0) : (val == TOP));
        if (load) begin
            nxt = ld_clamped;
        end else if (!en) begin
            nxt = val;
        end else if (dir) begin
            nxt = (val == '0) ? TOP : (val - W'(1));
        end else begin
            nxt = (val == TOP) ? '0 : (val + W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val <= '0;
        end else begin
            val <= nxt;
        end
    end

endmodule

// File: rtl/timer_core_param.sv
// Two-stage (MSB:LSB) modulo timer with run/pause FSM, end-match done flag and optional auto-reload.
// Latency: outputs update on the clk edge that samples tick/load/clear (1 cycle).
// Backpressure: none; priority rst > clear > load > tick, a tick coinciding with load/clear is dropped.
//   tick, run, mode            : count enable strobe, run level, direction (1 = down)
//   load, clear                : strobes loading loadval / resetval pairs
//   msb/lsb_loadval, _resetval : preset values (clamped to modulus-1)
//   msb/lsb_end                : end-match target
//   lsb_out, msb_out           : registered count
//   running, done, done_pulse, lsb_carry : status (done sticky, pulses one cycle)
module timer_core_param
    import timer_pkg::*;
#(
    parameter int DIGIT_W     = 8,
    parameter int LSB_MOD     = MOD_SEC,
    parameter int MSB_MOD     = MOD_SEC,
    parameter int AUTO_RELOAD = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               run,
    input  logic               mode,
    input  logic               load,
    input  logic               clear,
    input  logic [DIGIT_W-1:0] msb_loadval,
    input  logic [DIGIT_W-1:0] lsb_loadval,
    input  logic [DIGIT_W-1:0] msb_resetval,
    input  logic [DIGIT_W-1:0] lsb_resetval,
    input  logic [DIGIT_W-1:0] msb_end,
    input  logic [DIGIT_W-1:0] lsb_end,
    output logic [DIGIT_W-1:0] lsb_out,
    output logic [DIGIT_W-1:0] msb_out,
    output logic               running,
    output logic               done,
    output logic               done_pulse,
    output logic               lsb_carry
);

    localparam logic RELOAD_EN = (AUTO_RELOAD != 0);

    state_t state;
    state_t state_nxt;
    logic   reload_pend;   // auto-reload: next RUN tick loads instead of stepping
    logic   step;          // accepted tick in RUN
    logic   reload_now;
    logic   count_en;
    logic   stage_load;
    logic   match;
    logic   lsb_wrap;
    logic   msb_wrap;
    logic [DIGIT_W-1:0] lsb_ld;
    logic [DIGIT_W-1:0] msb_ld;
    logic [DIGIT_W-1:0] lsb_nxt;
    logic [DIGIT_W-1:0] msb_nxt;

    always_comb begin
        step       = tick & (state == ST_RUN) & ~load & ~clear;
        reload_now = step & reload_pend;
        count_en   = step & ~reload_pend;
        stage_load = clear | load | reload_now;
        lsb_ld     = clear ? lsb_resetval : lsb_loadval;
        msb_ld     = clear ? msb_resetval : msb_loadval;
        // Only a real step can match; loaded/cleared values never raise done.
        match      = count_en & (msb_nxt == msb_end) & (lsb_nxt == lsb_end);
    end

    timer_mod_stage #(.W(DIGIT_W), .MOD(LSB_MOD)) u_lsb (
        .clk    (clk),
        .rst    (rst),
        .en     (count_en),
        .dir    (mode),
        .load   (stage_load),
        .ld_val (lsb_ld),
        .val    (lsb_out),
        .nxt    (lsb_nxt),
        .wrap   (lsb_wrap)
    );

    // MSB steps only when the LSB crosses its boundary; its own wrap is the full rollover.
    timer_mod_stage #(.W(DIGIT_W), .MOD(MSB_MOD)) u_msb (
        .clk    (clk),
        .rst    (rst),
        .en     (lsb_wrap),
        .dir    (mode),
        .load   (stage_load),
        .ld_val (msb_ld),
        .val    (msb_out),
        .nxt    (msb_nxt),
        .wrap   (msb_wrap)
    );

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (run) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (match && !RELOAD_EN) state_nxt = ST_DONE;
                    else if (!run)           state_nxt = ST_PAUSE;
                end
                ST_PAUSE: if (run) state_nxt = ST_RUN;
                ST_DONE:  if (load) state_nxt = run ? ST_RUN : ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            running     <= 1'b0;
            done        <= 1'b0;
            done_pulse  <= 1'b0;
            lsb_carry   <= 1'b0;
            reload_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            running    <= (state_nxt == ST_RUN);
            done_pulse <= match;
            lsb_carry  <= lsb_wrap;
            if (clear || load) begin
                done        <= 1'b0;
                reload_pend <= 1'b0;
            end else if (match) begin
                done        <= 1'b1;
                reload_pend <= RELOAD_EN;
            end else if (reload_now) begin
                reload_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timer_core_param.sv
// Bench for timer_core_param: two instances (default; MSB_MOD=3 with auto-reload) sharing inputs,
// each checked every cycle against a count-as-integer reference model, plus a vector table
// and directed sequences.
module tb_timer_core_param;

    localparam int W = 8;
    localparam int LM[2] = '{60, 60};
    localparam int MM[2] = '{60, 3};
    localparam int AR[2] = '{0, 1};
    localparam int P_IDLE = 0, P_RUN = 1, P_PAUSE = 2, P_DONE = 3;

    logic clk, rst, tick, run, mode, load, clear;
    logic [W-1:0] msb_loadval, lsb_loadval, msb_resetval, lsb_resetval, msb_end, lsb_end;
    logic [W-1:0] lsb0, msb0, lsb1, msb1;
    logic run0, done0, dp0, cy0, run1, done1, dp1, cy1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the count is one integer msb*LSB_MOD+lsb modulo LSB_MOD*MSB_MOD.
    int m_tot[2], m_ph[2], m_done[2], m_dp[2], m_cy[2], m_pend[2];

    timer_core_param dut0 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .mode(mode), .load(load), .clear(clear),
        .msb_loadval(msb_loadval), .lsb_loadval(lsb_loadval),
        .msb_resetval(msb_resetval), .lsb_resetval(lsb_resetval),
        .msb_end(msb_end), .lsb_end(lsb_end),
        .lsb_out(lsb0), .msb_out(msb0), .running(run0), .done(done0),
        .done_pulse(dp0), .lsb_carry(cy0)
    );

    timer_core_param #(.DIGIT_W(W), .LSB_MOD(60), .MSB_MOD(3), .AUTO_RELOAD(1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .mode(mode), .load(load), .clear(clear),
        .msb_loadval(msb_loadval), .lsb_loadval(lsb_loadval),
        .msb_resetval(msb_resetval), .lsb_resetval(lsb_resetval),
        .msb_end(msb_end), .lsb_end(lsb_end),
        .lsb_out(lsb1), .msb_out(msb1), .running(run1), .done(done1),
        .done_pulse(dp1), .lsb_carry(cy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v, input int m);
        return (v >= m) ? m - 1 : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_tot[k] = 0; m_ph[k] = P_IDLE; m_done[k] = 0;
            m_dp[k] = 0; m_cy[k] = 0; m_pend[k] = 0;
        end
    endtask

    function automatic int next_phase(input int ph, input bit r);
        if (ph == P_IDLE && r)  return P_RUN;
        if (ph == P_RUN && !r)  return P_PAUSE;
        if (ph == P_PAUSE && r) return P_RUN;
        return ph;
    endfunction

    // Advance instance k by one clock edge using the inputs as currently driven.
    task automatic model_step(input int k);
        int n, lv, ns;
        n = LM[k] * MM[k];
        m_dp[k] = 0;
        m_cy[k] = 0;
        if (clear) begin
            m_tot[k] = clampv(int'(msb_resetval), MM[k]) * LM[k] + clampv(int'(lsb_resetval), LM[k]);
            m_ph[k] = P_IDLE; m_done[k] = 0; m_pend[k] = 0;
        end else if (load) begin
            m_tot[k] = clampv(int'(msb_loadval), MM[k]) * LM[k] + clampv(int'(lsb_loadval), LM[k]);
            m_done[k] = 0; m_pend[k] = 0;
            if (m_ph[k] == P_DONE) m_ph[k] = run ? P_RUN : P_IDLE;
            else m_ph[k] = next_phase(m_ph[k], run);
        end else begin
            ns = next_phase(m_ph[k], run);
            if (m_ph[k] == P_RUN && tick) begin
                if (m_pend[k] != 0) begin
                    m_tot[k] = clampv(int'(msb_loadval), MM[k]) * LM[k] + clampv(int'(lsb_loadval), LM[k]);
                    m_pend[k] = 0;
                end else begin
                    lv = m_tot[k] % LM[k];
                    m_cy[k] = mode ? int'(lv == 0) : int'(lv == LM[k] - 1);
                    m_tot[k] = mode ? (m_tot[k] + n - 1) % n : (m_tot[k] + 1) % n;
                    if (int'(lsb_end) < LM[k] && int'(msb_end) < MM[k] &&
                        m_tot[k] == int'(msb_end) * LM[k] + int'(lsb_end)) begin
                        m_dp[k] = 1; m_done[k] = 1;
                        if (AR[k] != 0) m_pend[k] = 1;
                        else ns = P_DONE;
                    end
                end
            end
            m_ph[k] = ns;
        end
    endtask

    task automatic compare_all();
        check("lsb_out0", int'(lsb0), m_tot[0] % LM[0]);
        check("msb_out0", int'(msb0), m_tot[0] / LM[0]);
        check("running0", int'(run0), int'(m_ph[0] == P_RUN));
        check("done0", int'(done0), m_done[0]);
        check("done_pulse0", int'(dp0), m_dp[0]);
        check("lsb_carry0", int'(cy0), m_cy[0]);
        check("lsb_out1", int'(lsb1), m_tot[1] % LM[1]);
        check("msb_out1", int'(msb1), m_tot[1] / LM[1]);
        check("running1", int'(run1), int'(m_ph[1] == P_RUN));
        check("done1", int'(done1), m_done[1]);
        check("done_pulse1", int'(dp1), m_dp[1]);
        check("lsb_carry1", int'(cy1), m_cy[1]);
    endtask

    // Inputs are driven just after a rising edge; outputs are sampled 1 time unit after the next one.
    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic strobe_clear();
        tick = 0; load = 0; clear = 0;
    endtask

    task automatic async_reset(input string name);
        rst = 1'b1;
        #1;
        model_reset();
        check({name, "_lsb0"}, int'(lsb0), 0);
        check({name, "_msb0"}, int'(msb0), 0);
        check({name, "_lsb1"}, int'(lsb1), 0);
        check({name, "_msb1"}, int'(msb1), 0);
        compare_all();
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit tick, run, mode, load, clear;
        int e_lsb, e_msb;
        bit e_run, e_done, e_dp, e_cy;
    } vec_t;

    initial begin
        vec_t vt[14];
        int pulses;
        int exp_l[4];
        int exp_p[4];

        vt[0]  = '{0,0,0,1,0, 58,0, 0,0,0,0};
        vt[1]  = '{1,0,0,0,0, 58,0, 0,0,0,0};
        vt[2]  = '{0,1,0,0,0, 58,0, 1,0,0,0};
        vt[3]  = '{1,1,0,0,0, 59,0, 1,0,0,0};
        vt[4]  = '{1,1,0,0,0,  0,1, 0,1,1,1};
        vt[5]  = '{1,1,0,0,0,  0,1, 0,1,0,0};
        vt[6]  = '{1,1,0,1,1,  7,3, 0,0,0,0};
        vt[7]  = '{0,1,1,0,0,  7,3, 1,0,0,0};
        vt[8]  = '{1,1,1,0,0,  6,3, 1,0,0,0};
        vt[9]  = '{1,0,1,0,0,  5,3, 0,0,0,0};
        vt[10] = '{1,0,1,0,0,  5,3, 0,0,0,0};
        vt[11] = '{1,0,0,1,0, 58,0, 0,0,0,0};
        vt[12] = '{0,1,1,0,0, 58,0, 1,0,0,0};
        vt[13] = '{1,1,1,0,0, 57,0, 1,0,0,0};

        rst = 1; tick = 0; run = 0; mode = 0; load = 0; clear = 0;
        msb_loadval = 0; lsb_loadval = 58; msb_resetval = 3; lsb_resetval = 7;
        msb_end = 1; lsb_end = 0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 0;

        // Vector table on the default instance.
        for (int i = 0; i < 14; i++) begin
            tick = vt[i].tick; run = vt[i].run; mode = vt[i].mode;
            load = vt[i].load; clear = vt[i].clear;
            cycle();
            check($sformatf("vec%0d_lsb", i), int'(lsb0), vt[i].e_lsb);
            check($sformatf("vec%0d_msb", i), int'(msb0), vt[i].e_msb);
            check($sformatf("vec%0d_running", i), int'(run0), int'(vt[i].e_run));
            check($sformatf("vec%0d_done", i), int'(done0), int'(vt[i].e_done));
            check($sformatf("vec%0d_done_pulse", i), int'(dp0), int'(vt[i].e_dp));
            check($sformatf("vec%0d_carry", i), int'(cy0), int'(vt[i].e_cy));
        end
        strobe_clear();

        // Count up from reset to 2:00: exactly one done_pulse, then hold.
        async_reset("rst_a");
        msb_end = 2; lsb_end = 0; mode = 0; run = 1; tick = 1;
        pulses = 0;
        for (int i = 0; i < 125; i++) begin
            cycle();
            pulses += int'(dp0);
        end
        check("up_pulses", pulses, 1);
        check("up_hold_msb", int'(msb0), 2);
        check("up_hold_lsb", int'(lsb0), 0);
        check("up_done", int'(done0), 1);
        check("up_running", int'(run0), 0);

        // Count down from 1:00 to 0:00.
        tick = 0; load = 1; msb_loadval = 1; lsb_loadval = 0; msb_end = 0; lsb_end = 0; mode = 1;
        cycle();
        load = 0; tick = 1;
        cycle();
        check("down_first_lsb", int'(lsb0), 59);
        check("down_first_msb", int'(msb0), 0);
        check("down_first_carry", int'(cy0), 1);
        for (int i = 0; i < 59; i++) cycle();
        check("down_done", int'(done0), 1);
        check("down_end_lsb", int'(lsb0), 0);
        tick = 0;

        // Auto-reload on the second instance: 0:05 .. 0:08 then back to 0:05.
        exp_l = '{6, 7, 8, 5};
        exp_p = '{0, 0, 1, 0};
        mode = 0; load = 1; msb_loadval = 0; lsb_loadval = 5; msb_end = 0; lsb_end = 8;
        cycle();
        load = 0; tick = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("ar%0d_lsb", i), int'(lsb1), exp_l[i]);
            check($sformatf("ar%0d_pulse", i), int'(dp1), exp_p[i]);
            check($sformatf("ar%0d_running", i), int'(run1), 1);
        end

        // Full wrap with MSB_MOD=3: 2:59 -> 0:00, then match at 1:00.
        tick = 0; load = 1; msb_loadval = 2; lsb_loadval = 59; msb_end = 1; lsb_end = 0;
        cycle();
        load = 0; tick = 1;
        cycle();
        check("wrap_lsb", int'(lsb1), 0);
        check("wrap_msb", int'(msb1), 0);
        check("wrap_carry", int'(cy1), 1);
        for (int i = 0; i < 60; i++) cycle();
        check("wrap_match_msb", int'(msb1), 1);
        check("wrap_match_pulse", int'(dp1), 1);
        cycle();
        tick = 0;
        #2;
        async_reset("rst_mid");

        // Load and clear values beyond the modulus clamp.
        load = 1; lsb_loadval = 70; msb_loadval = 5;
        cycle();
        load = 0;
        check("clamp_lsb0", int'(lsb0), 59);
        check("clamp_msb1", int'(msb1), 2);
        clear = 1; lsb_resetval = 200; msb_resetval = 1;
        cycle();
        clear = 0;
        check("clamp_clear_lsb1", int'(lsb1), 59);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick  = ($urandom_range(0, 3) != 0);
            run   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            load  = ($urandom_range(0, 39) == 0);
            clear = ($urandom_range(0, 59) == 0);
            if (load || clear) begin
                lsb_loadval  = W'($urandom_range(0, 70));
                msb_loadval  = W'($urandom_range(0, 4));
                lsb_resetval = W'($urandom_range(0, 70));
                msb_resetval = W'($urandom_range(0, 4));
                lsb_end      = W'($urandom_range(0, 63));
                msb_end      = W'($urandom_range(0, 3));
            end
            cycle();
        end
        strobe_clear();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
